mgmt_protect_pwrseq: RTL
========================

// Module: mgmt_protect_pwrseq
// PURPOSE
//  Consumes the user-domain power-good levels mprj_vdd_logic1 / mprj2_vdd_logic1 (driven from the 3.3V domains).
//  Synchronises and debounces them, then sequences the user project up and down: clock enable, reset release,
//  then management-interface enable. Its outputs gate the mgmt_protect isolation buffers (WB, LA, user clock).
//  Loss of either domain forces isolation immediately and latches a fault for firmware.
// PARAMETERS
//  SYNC_STAGES      2   flops per power-good synchroniser (>=2)
//  DEBOUNCE_CYCLES  16  consecutive high samples needed to declare a domain good (>=1)
//  RST_DELAY        8   cycles of running clock before reset release / after reset assert (>=1)
// PORTS
//  caravel_clk       in   1  management clock
//  caravel_rstn      in   1  async active-low reset
//  mprj_vdd_logic1   in   1  user1 domain power-good, asynchronous
//  mprj2_vdd_logic1  in   1  user2 domain power-good, asynchronous
//  ena_req           in   1  firmware request to enable user project (level)
//  user1_pg          out  1  debounced user1 power-good
//  user2_pg          out  1  debounced user2 power-good
//  user_clk_ena      out  1  enable for user clock gate
//  user_resetn       out  1  active-low reset to user project
//  iface_ena         out  1  enable for WB/LA isolation buffers
//  ena_ack           out  1  high while in ACTIVE
//  fault             out  1  sticky: power lost while sequenced up
// BEHAVIOUR
//  Reset (caravel_rstn=0, async): sync flops, debounce counters, FSM -> OFF, all outputs 0 (user_resetn=0).
//  All outputs are registered; no combinational input-to-output path.
//  Debounce, per domain: s = synchroniser output; s=0 -> cnt=0, pg=0 the next cycle (fast drop).
//   s=1 -> cnt increments, saturating at DEBOUNCE_CYCLES; pg=1 once cnt reaches DEBOUNCE_CYCLES.
//   Latency: input rise to pg rise = SYNC_STAGES+DEBOUNCE_CYCLES cycles; a glitch shorter than the window never sets pg.
//  pg_all = user1_pg & user2_pg. Sequence counter seq_cnt is sized $clog2(RST_DELAY+1).
//  FSM:
//   OFF:      clk_ena=0, resetn=0, iface=0. ena_req & pg_all & !fault -> CLK_ON, seq_cnt=0.
//   CLK_ON:   clk_ena=1, resetn=0. seq_cnt++; at seq_cnt==RST_DELAY-1 -> RST_REL.
//   RST_REL:  clk_ena=1, resetn=1, iface=0 for exactly 1 cycle -> ACTIVE.
//   ACTIVE:   clk_ena=1, resetn=1, iface=1, ena_ack=1. !ena_req -> SHUTDOWN, seq_cnt=0.
//   SHUTDOWN: iface=0, resetn=0, clk_ena=1. seq_cnt++; at RST_DELAY-1 -> OFF.
//  Power loss: !pg_all in CLK_ON/RST_REL/ACTIVE/SHUTDOWN -> OFF next edge; all outputs 0; fault set.
//   Power loss takes priority over every other transition.
//  fault: cleared only in a cycle where ena_req=0. While fault=1 the FSM stays in OFF, so firmware must drop
//   and reassert ena_req to restart. fault set and ena_req=0 in the same cycle -> set wins.
//  ena_req dropped during CLK_ON or RST_REL: finish to ACTIVE, then shut down the next cycle (no abort path).
//  ena_req re-raised during SHUTDOWN: ignored until OFF is reached.
//  Cycle counts (defaults), ena_req rise in OFF with pg_all=1:
//   clk_ena rises +1; resetn rises +9; iface_ena and ena_ack rise +10.
//  Reset mid-sequence: async return to OFF state; outputs drop immediately.
// TESTING
//  1 Both pg inputs rise at t0 -> user1_pg/user2_pg rise exactly 18 cycles later.
//    A 10-cycle high pulse on mprj_vdd_logic1 -> user1_pg stays 0.
//  2 pg_all=1, ena_req rises -> clk_ena at +1, resetn at +9, iface_ena/ena_ack at +10.
//    Then drop ena_req -> iface_ena and resetn low at +1, clk_ena low at +9, state OFF.
//  3 In ACTIVE, mprj2_vdd_logic1 falls -> user2_pg low after SYNC_STAGES+1 cycles;
//    all enables 0 and fault=1 on the next edge.
//    ena_req held high -> no restart; drop ena_req -> fault clears; reassert -> full sequence again.
//  4 ena_req pulsed low for 1 cycle during CLK_ON -> reaches ACTIVE, then enters SHUTDOWN on the following cycle.
//  5 caravel_rstn pulsed low while in ACTIVE -> all outputs 0 asynchronously;
//    after release, pg rises again only after 18 cycles.
//  6 Power loss while in SHUTDOWN -> OFF on the next edge with fault=1 (same cycle as ena_req=0: fault still set).

Source files
------------

// File: rtl/mgmt_protect_pwrseq.sv
// -----------------------------------------------------------------------------
// mgmt_protect_pwrseq
//
// Power sequencer for the user project behind the mgmt_protect isolation
// buffers. The two user-domain power-good levels are synchronised and
// debounced. The block then brings the user project up in this order: clock
// enable, reset release, management-interface enable. It takes the project
// down in the reverse order. If either domain is lost while the project is
// sequenced up, isolation is forced at once and a sticky fault is latched.
//
// Ports
//   caravel_clk       in   management clock
//   caravel_rstn      in   asynchronous active-low reset
//   mprj_vdd_logic1   in   user1 domain power-good (asynchronous)
//   mprj2_vdd_logic1  in   user2 domain power-good (asynchronous)
//   ena_req           in   firmware enable request (level)
//   user1_pg          out  debounced user1 power-good
//   user2_pg          out  debounced user2 power-good
//   user_clk_ena      out  user clock gate enable
//   user_resetn       out  active-low reset to the user project
//   iface_ena         out  WB/LA isolation buffer enable
//   ena_ack           out  high while the project is fully active
//   fault             out  sticky: power lost while sequenced up
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mgmt_protect_pwrseq #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RST_DELAY       = 8
) (
    input  logic caravel_clk,
    input  logic caravel_rstn,
    input  logic mprj_vdd_logic1,
    input  logic mprj2_vdd_logic1,
    input  logic ena_req,
    output logic user1_pg,
    output logic user2_pg,
    output logic user_clk_ena,
    output logic user_resetn,
    output logic iface_ena,
    output logic ena_ack,
    output logic fault
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SEQ_W = $clog2(RST_DELAY + 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(RST_DELAY - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_CLK_ON,
        ST_RST_REL,
        ST_ACTIVE,
        ST_SHUTDOWN
    } state_t;

    // Index 0 is user1, index 1 is user2.
    logic [1:0] pg_raw;
    assign pg_raw = {mprj2_vdd_logic1, mprj_vdd_logic1};

    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]                  pg_q, pg_d;

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic             drop_pend_q, drop_pend_d;
    logic             fault_q, fault_d;
    logic             clk_ena_q, clk_ena_d;
    logic             resetn_q, resetn_d;
    logic             iface_q, iface_d;
    logic             ack_q, ack_d;

    logic pg_all;
    logic power_loss;

    // Synchroniser and debounce. A low synchronised sample clears the counter
    // and drops pg on the next edge. A high sample counts up, saturating at
    // the window length.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pg_raw[i]};
            if (!sync_q[i][SYNC_STAGES-1]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_MAX) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            pg_d[i] = (cnt_d[i] == DEB_MAX);
        end
    end

    assign pg_all     = &pg_q;
    assign power_loss = (state_q != ST_OFF) && !pg_all;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        seq_cnt_d   = seq_cnt_q;
        drop_pend_d = drop_pend_q;

        if (power_loss) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (ena_req && pg_all && !fault_q) begin
                        state_d   = ST_CLK_ON;
                        seq_cnt_d = '0;
                    end
                end
                ST_CLK_ON: begin
                    // There is no abort path. A drop seen during power-up is
                    // remembered and honoured once ACTIVE is reached.
                    if (!ena_req) drop_pend_d = 1'b1;
                    if (seq_cnt_q == SEQ_LAST) begin
                        state_d = ST_RST_REL;
                    end else begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end
                ST_RST_REL: begin
                    if (!ena_req) drop_pend_d = 1'b1;
                    state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!ena_req || drop_pend_q) begin
                        state_d   = ST_SHUTDOWN;
                        seq_cnt_d = '0;
                    end
                end
                ST_SHUTDOWN: begin
                    if (seq_cnt_q == SEQ_LAST) begin
                        state_d = ST_OFF;
                    end else begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        if (state_d == ST_OFF || state_d == ST_SHUTDOWN) drop_pend_d = 1'b0;

        // A fault being set wins over a clear in the same cycle.
        fault_d = fault_q;
        if (power_loss) begin
            fault_d = 1'b1;
        end else if (!ena_req) begin
            fault_d = 1'b0;
        end

        // The outputs are decoded from the next state, so that they change on
        // the same edge as the state.
        clk_ena_d = (state_d != ST_OFF);
        resetn_d  = (state_d == ST_RST_REL) || (state_d == ST_ACTIVE);
        iface_d   = (state_d == ST_ACTIVE);
        ack_d     = (state_d == ST_ACTIVE);
    end

    // NOTE: the synchroniser chains are reset along with everything else, so pg always starts low.
    always_ff @(posedge caravel_clk or negedge caravel_rstn) begin
        if (!caravel_rstn) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            pg_q        <= '0;
            state_q     <= ST_OFF;
            seq_cnt_q   <= '0;
            drop_pend_q <= 1'b0;
            fault_q     <= 1'b0;
            clk_ena_q   <= 1'b0;
            resetn_q    <= 1'b0;
            iface_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            pg_q        <= pg_d;
            state_q     <= state_d;
            seq_cnt_q   <= seq_cnt_d;
            drop_pend_q <= drop_pend_d;
            fault_q     <= fault_d;
            clk_ena_q   <= clk_ena_d;
            resetn_q    <= resetn_d;
            iface_q     <= iface_d;
            ack_q       <= ack_d;
        end
    end

    assign user1_pg     = pg_q[0];
    assign user2_pg     = pg_q[1];
    assign user_clk_ena = clk_ena_q;
    assign user_resetn  = resetn_q;
    assign iface_ena    = iface_q;
    assign ena_ack      = ack_q;
    assign fault        = fault_q;

endmodule
